// File: rtl/alu_serial_ctrl.sv
// Bit-serial operand sequencer for a single 1-bit ALU slice.
// Walks LSB to MSB, chaining carry/borrow, and assembles the result.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_operand,
    input  logic [WIDTH-1:0] b_operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [3:0]       slice_sel,
    input  logic             slice_res,
    input  logic             slice_cout
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]      op_reg;
    logic [IW-1:0]   idx;
    logic            carry;

    logic [3:0]      sel_dec;
    logic            known;
    logic            uses_carry;
    logic            is_slt;
    logic            bit_val;
    logic            run;

    always_comb begin
        sel_dec    = OP_AND;
        known      = 1'b1;
        uses_carry = 1'b0;
        is_slt     = 1'b0;
        unique case (1'b1)
            (op_reg == OP_AND): sel_dec = OP_AND;
            (op_reg == OP_OR):  sel_dec = OP_OR;
            (op_reg == OP_ADD): begin
                sel_dec    = OP_ADD;
                uses_carry = 1'b1;
            end
            (op_reg == OP_SUB): begin
                sel_dec    = OP_SUB;
                uses_carry = 1'b1;
            end
            // SLT is a full subtract; only the final borrow survives
            (op_reg == OP_SLT): begin
                sel_dec    = OP_SUB;
                uses_carry = 1'b1;
                is_slt     = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    assign run       = (state == S_RUN);
    assign bit_val   = known & slice_res;
    assign slice_a   = run ? a_reg[idx] : 1'b0;
    assign slice_b   = run ? b_reg[idx] : 1'b0;
    assign slice_cin = run ? carry : 1'b0;
    assign slice_sel = run ? sel_dec : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry_flag <= 1'b0;
            carry      <= 1'b0;
            idx        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg      <= a_operand;
                        b_reg      <= b_operand;
                        op_reg     <= op;
                        idx        <= '0;
                        carry      <= 1'b0;
                        result     <= '0;
                        carry_flag <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    result[idx] <= bit_val;
                    carry       <= slice_cout;
                    if (idx == LAST) begin
                        carry_flag <= uses_carry & slice_cout;
                        if (is_slt) begin
                            result <= {{(WIDTH-1){1'b0}}, slice_cout};
                        end
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed scoreboard bench for alu_serial_ctrl.
// Includes a behavioural 1-bit ALU slice driven by the controller.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'b0000;
    logic [W-1:0] a_operand = '0;
    logic [W-1:0] b_operand = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_flag;
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic [3:0]   slice_sel;
    logic         slice_res;
    logic         slice_cout;

    typedef struct {
        logic [W-1:0] res;
        logic         cf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   dones = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a_operand  (a_operand),
        .b_operand  (b_operand),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_flag (carry_flag),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sel  (slice_sel),
        .slice_res  (slice_res),
        .slice_cout (slice_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        slice_res  = 1'b0;
        slice_cout = 1'b0;
        case (slice_sel)
            4'b0000: slice_res = slice_a & slice_b;
            4'b0001: slice_res = slice_a | slice_b;
            4'b0010: begin
                slice_res  = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
            end
            4'b0011: begin
                slice_res  = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (~slice_a & slice_b) | (~(slice_a ^ slice_b) & slice_cin);
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        e.res = '0;
        e.cf  = 1'b0;
        case (o)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.cf  = s[W];
            end
            4'd3: begin
                e.res = a - b;
                e.cf  = (a < b);
            end
            4'd4: begin
                e.res = (a < b) ? W'(1) : W'(0);
                e.cf  = (a < b);
            end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'(result), 32'(mon_e.res));
                check("carry_flag", 32'(carry_flag), 32'(mon_e.cf));
            end
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_at);
        int n;
        logic [3:0] sel_exp;
        sel_exp = (o == 4'd2) ? 4'd2 :
                  (o == 4'd3 || o == 4'd4) ? 4'd3 :
                  (o == 4'd1) ? 4'd1 : 4'd0;
        @(posedge clk); #1;
        op = o;
        a_operand = a;
        b_operand = b;
        start = 1'b1;
        sb.push_back(model(o, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        op = 4'hF;
        a_operand = ~a;
        b_operand = ~b;
        n = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (n >= W + 4) break;
            check("slice_sel", 32'(slice_sel), 32'(sel_exp));
            check("busy_run", 32'(busy), 32'd1);
            if (n == inj_at) begin
                start = 1'b1;
                op = 4'd2;
                a_operand = 8'h11;
                b_operand = 8'h22;
            end
            if (n == inj_at + 1) start = 1'b0;
            n++;
        end
        check("latency", 32'(n), 32'(W));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cf", 32'(carry_flag), 32'd0);
        check("rst_sel", 32'(slice_sel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd2, 8'hF0, 8'h20, -1);
        run_op(4'd3, 8'h05, 8'h07, -1);
        run_op(4'd3, 8'h07, 8'h05, -1);
        run_op(4'd4, 8'h03, 8'h80, -1);
        run_op(4'd4, 8'h80, 8'h03, -1);
        run_op(4'd0, 8'hC3, 8'h5A, -1);
        repeat (3) @(negedge clk);
        check("result_held", 32'(result), 32'h42);
        run_op(4'd1, 8'hC3, 8'h5A, -1);
        run_op(4'd7, 8'hC3, 8'h5A, -1);

        d0 = dones;
        run_op(4'd2, 8'h0F, 8'h01, 3);
        repeat (W + 4) @(negedge clk);
        check("one_done", 32'(dones - d0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        @(posedge clk); #1;
        op = 4'd2;
        a_operand = 8'hFF;
        b_operand = 8'hFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_cin", 32'(slice_cin), 32'd1);
        d0 = dones;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_slice_a", 32'(slice_a), 32'd0);
        check("abort_slice_b", 32'(slice_b), 32'd0);
        check("abort_slice_cin", 32'(slice_cin), 32'd0);
        check("abort_slice_sel", 32'(slice_sel), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("abort_no_done", 32'(dones - d0), 32'd0);
        run_op(4'd2, 8'h01, 8'h01, -1);

        repeat (2) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
